spi_deserializer: RTL and testbench

SPI_DESERIALIZER -- requirements
Module: spi_deserializer

---
 rtl/spi_deserializer.sv | 162 ++++++++++++++++
 tb/tb_spi_deserializer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_deserializer.sv
// SPI-style serial-to-parallel receiver.
// The serial pins are synchronized into the clk domain. Edges of SPI_clk
// and CS are detected there and drive a HUNT/RECV/LATCH state machine.
// A CS high pulse ends a frame: a frame with exactly Shift_BitCount bits
// updates Data_Register, and any other length raises Frame_Error.

module spi_deserializer #(
  parameter int Register_Width = 32,
  parameter int Shift_BitCount = 24,
  parameter int Sync_Stages    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      DataBit,
  input  logic                      SPI_clk,
  input  logic                      CS,
  output logic [Register_Width-1:0] Data_Register,
  output logic                      Data_Valid,
  output logic                      Frame_Error
);

  // The counter must be able to hold Shift_BitCount+1, which is the overrun marker.
  localparam int CntWidth = $clog2(Shift_BitCount + 2);
  localparam logic [CntWidth-1:0] CntFull = CntWidth'(Shift_BitCount);
  localparam logic [CntWidth-1:0] CntSat  = CntWidth'(Shift_BitCount + 1);
  localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);

  typedef enum logic [1:0] {
    HUNT,
    RECV,
    LATCH
  } state_t;

  logic [Sync_Stages-1:0]    dataSync_q;
  logic [Sync_Stages-1:0]    sclkSync_q;
  logic [Sync_Stages-1:0]    csSync_q;
  logic                      dataSyncOut;
  logic                      sclkSyncOut;
  logic                      csSyncOut;

  logic                      dataDly_q;
  logic                      sclkDly_q;
  logic                      csDly_q;
  logic                      sclkRise_q;
  logic                      csRise_q;
  logic                      csFall_q;

  state_t                    state_q;
  logic [Shift_BitCount-1:0] sh_q;
  logic [Shift_BitCount-1:0] shNext_d;
  logic [Register_Width-1:0] regNext_d;
  logic [CntWidth-1:0]       bitCount_q;
  logic                      goodPend_q;
  logic                      badPend_q;

  assign dataSyncOut = dataSync_q[Sync_Stages-1];
  assign sclkSyncOut = sclkSync_q[Sync_Stages-1];
  assign csSyncOut   = csSync_q[Sync_Stages-1];

  // DataBit gets the same synchronizer depth as SPI_clk, so the two stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dataSync_q <= '0;
      sclkSync_q <= '0;
      csSync_q   <= '0;
    end else begin
      dataSync_q <= {dataSync_q[Sync_Stages-2:0], DataBit};
      sclkSync_q <= {sclkSync_q[Sync_Stages-2:0], SPI_clk};
      csSync_q   <= {csSync_q[Sync_Stages-2:0], CS};
    end
  end

  // Edge pulses are registered, and the data bit is delayed with them so that
  // dataDly_q is the bit that was present when the SPI_clk rise was seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dataDly_q  <= 1'b0;
      sclkDly_q  <= 1'b0;
      csDly_q    <= 1'b0;
      sclkRise_q <= 1'b0;
      csRise_q   <= 1'b0;
      csFall_q   <= 1'b0;
    end else begin
      dataDly_q  <= dataSyncOut;
      sclkDly_q  <= sclkSyncOut;
      csDly_q    <= csSyncOut;
      sclkRise_q <= sclkSyncOut & ~sclkDly_q;
      csRise_q   <= csSyncOut & ~csDly_q;
      csFall_q   <= ~csSyncOut & csDly_q;
    end
  end

  // New bits enter at the top, so the first bit received (the LSB) ends up in bit 0.
  if (Shift_BitCount > 1) begin : gShiftWide
    assign shNext_d = {dataDly_q, sh_q[Shift_BitCount-1:1]};
  end else begin : gShiftOne
    assign shNext_d = dataDly_q;
  end

  // Zero-extend the shift register to the width of the output word.
  always_comb begin
    regNext_d = '0;
    regNext_d[Shift_BitCount-1:0] = sh_q;
  end

  // Frame state machine. The CS rising edge is checked before the SPI_clk edge,
  // so a clock edge that coincides with the end of the frame is never shifted in.
  // The frame verdict is held for one cycle in a pending flag and then issued
  // as a registered pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HUNT;
      sh_q          <= '0;
      bitCount_q    <= '0;
      goodPend_q    <= 1'b0;
      badPend_q     <= 1'b0;
      Data_Register <= '0;
      Data_Valid    <= 1'b0;
      Frame_Error   <= 1'b0;
    end else begin
      goodPend_q  <= 1'b0;
      badPend_q   <= 1'b0;
      Data_Valid  <= goodPend_q;
      Frame_Error <= badPend_q;
      if (goodPend_q) begin
        Data_Register <= regNext_d;
      end
      case (state_q)
        HUNT: begin
          if (csFall_q) begin
            bitCount_q <= '0;
            sh_q       <= '0;
            state_q    <= RECV;
          end
        end
        RECV: begin
          if (csRise_q) begin
            state_q    <= LATCH;
            goodPend_q <= (bitCount_q == CntFull);
            badPend_q  <= (bitCount_q != CntFull);
          end else if (sclkRise_q) begin
            sh_q <= shNext_d;
            if (bitCount_q != CntSat) begin
              bitCount_q <= bitCount_q + CntOne;
            end
          end
        end
        LATCH: begin
          if (csFall_q) begin
            bitCount_q <= '0;
            sh_q       <= '0;
            state_q    <= RECV;
          end
        end
        default: begin
          state_q <= HUNT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_deserializer.sv
// Self-checking bench for spi_deserializer.
// Frames are driven on the pins with a fixed half period. The expected result
// of each frame comes from a simple rule: a frame counts only if a CS falling
// edge has been seen since reset, and it is good only if it holds exactly 24 bits.
// The expected word is rebuilt from the transmitted bits, LSB first.

`timescale 1ns/1ps

module tb_spi_deserializer;

  localparam int RW = 32;
  localparam int N  = 24;
  localparam int S  = 2;
  localparam int H  = 21;

  logic          clk = 1'b0;
  logic          rst;
  logic          DataBit;
  logic          SPI_clk;
  logic          CS;
  logic [RW-1:0] Data_Register;
  logic          Data_Valid;
  logic          Frame_Error;

  int            vectors     = 0;
  int            miscompares = 0;
  int            dvCount     = 0;
  int            feCount     = 0;
  bit            armed       = 1'b0;
  logic [RW-1:0] expReg      = '0;

  spi_deserializer #(
    .Register_Width(RW),
    .Shift_BitCount(N),
    .Sync_Stages(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .DataBit(DataBit),
    .SPI_clk(SPI_clk),
    .CS(CS),
    .Data_Register(Data_Register),
    .Data_Valid(Data_Valid),
    .Frame_Error(Frame_Error)
  );

  // System clock: 10 ns period.
  always #5 clk = ~clk;

  // Count output pulses and make sure Data_Valid and Frame_Error are never high together.
  always @(negedge clk) begin
    if (!rst) begin
      if (Data_Valid) dvCount++;
      if (Frame_Error) feCount++;
      vectors++;
      if (Data_Valid && Frame_Error) begin
        miscompares++;
        $display("[TB] FAIL exclusive_pulses: Data_Valid=%0b Frame_Error=%0b required not both 1", Data_Valid, Frame_Error);
      end
    end
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends nbits bits, LSB first. DataBit changes while SPI_clk falls, and each level is held for H clks.
  task automatic shiftBits(input logic [63:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      DataBit = bits[i];
      SPI_clk = 1'b0;
      waitClk(H);
      SPI_clk = 1'b1;
      waitClk(H);
    end
  endtask

  // Runs one frame and checks the outputs on every cycle after CS rises.
  task automatic runFrame(input logic [63:0] bits, input int nbits, input bit simul, input string name);
    int            dv0;
    int            fe0;
    bit            good;
    bit            bad;
    bit            expDv;
    bit            expFe;
    logic [RW-1:0] newReg;
    logic [RW-1:0] expR;
    if (CS === 1'b1) begin
      CS    = 1'b0;
      armed = 1'b1;
    end
    waitClk(H);
    dv0 = dvCount;
    fe0 = feCount;
    shiftBits(bits, nbits);
    SPI_clk = 1'b0;
    waitClk(H);
    if (simul) SPI_clk = 1'b1;
    CS = 1'b1;
    good   = armed && (nbits == N);
    bad    = armed && (nbits != N);
    newReg = '0;
    for (int i = 0; i < N; i++) newReg[i] = bits[i];
    if (!good) newReg = expReg;
    for (int k = 1; k <= H; k++) begin
      waitClk(1);
      expDv = good && (k == S + 3);
      expFe = bad && (k == S + 3);
      expR  = (k >= S + 3) ? newReg : expReg;
      vectors += 3;
      if (Data_Valid !== expDv) begin
        miscompares++;
        $display("[TB] FAIL %s data_valid cycle %0d: got %0b expected %0b", name, k, Data_Valid, expDv);
      end
      if (Frame_Error !== expFe) begin
        miscompares++;
        $display("[TB] FAIL %s frame_error cycle %0d: got %0b expected %0b", name, k, Frame_Error, expFe);
      end
      if (Data_Register !== expR) begin
        miscompares++;
        $display("[TB] FAIL %s data_register cycle %0d: got %h expected %h", name, k, Data_Register, expR);
      end
    end
    expReg  = newReg;
    SPI_clk = 1'b0;
    vectors += 2;
    if ((dvCount - dv0) != int'(good)) begin
      miscompares++;
      $display("[TB] FAIL %s valid_pulses: got %0d expected %0d", name, dvCount - dv0, int'(good));
    end
    if ((feCount - fe0) != int'(bad)) begin
      miscompares++;
      $display("[TB] FAIL %s error_pulses: got %0d expected %0d", name, feCount - fe0, int'(bad));
    end
  endtask

  task automatic checkZeroOutputs(input string name);
    vectors += 3;
    if (Data_Register !== '0) begin
      miscompares++;
      $display("[TB] FAIL %s data_register: got %h expected 0", name, Data_Register);
    end
    if (Data_Valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s data_valid: got %0b expected 0", name, Data_Valid);
    end
    if (Frame_Error !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s frame_error: got %0b expected 0", name, Frame_Error);
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    CS      = 1'b1;
    SPI_clk = 1'b0;
    DataBit = 1'b0;
    armed   = 1'b0;
    expReg  = '0;
    waitClk(3);
    checkZeroOutputs("reset");
    rst = 1'b0;
    waitClk(5);
  endtask

  task automatic test_good_frame();
    runFrame(64'h0000_0000_00A5_C3E1, N, 1'b0, "good_frame");
  endtask

  task automatic test_short_frame();
    runFrame({$urandom, $urandom}, N - 1, 1'b0, "short_frame");
  endtask

  task automatic test_overrun();
    runFrame({$urandom, $urandom}, N + 2, 1'b0, "overrun");
    runFrame({$urandom, $urandom}, 56, 1'b0, "overrun_long");
  endtask

  task automatic test_back_to_back();
    runFrame(64'h0000_0000_0000_0001, N, 1'b0, "b2b_first");
    runFrame(64'h0000_0000_00FF_FFFF, N, 1'b0, "b2b_second");
  endtask

  task automatic test_random();
    int len;
    for (int f = 0; f < 6; f++) begin
      case ($urandom_range(0, 3))
        0: len = N - 1;
        1: len = N + 1;
        2: len = $urandom_range(1, 30);
        default: len = N;
      endcase
      runFrame({$urandom, $urandom}, len, 1'b0, "random");
    end
  endtask

  task automatic test_simultaneous();
    runFrame({$urandom, $urandom}, N, 1'b1, "simultaneous");
  endtask

  task automatic test_reset_mid_frame();
    CS    = 1'b0;
    armed = 1'b1;
    waitClk(H);
    shiftBits({$urandom, $urandom}, 10);
    rst = 1'b1;
    #1;
    checkZeroOutputs("reset_mid_frame");
    expReg = '0;
    armed  = 1'b0;
    waitClk(3);
    rst = 1'b0;
    waitClk(2);
    runFrame({$urandom, $urandom}, N, 1'b0, "unframed_after_reset");
    runFrame({$urandom, $urandom}, N, 1'b0, "framed_after_reset");
  endtask

  // Run each scenario in order, then print the summary.
  initial begin
    test_reset();
    test_good_frame();
    test_short_frame();
    test_overrun();
    test_back_to_back();
    test_random();
    test_simultaneous();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
